// File: rtl/matrix_input_buffer.sv
// Loads L vectors from memory into a local buffer, then streams the buffer R times
// to the downstream processor. A single instruction drives IDLE -> LOAD -> STREAM -> IDLE.
module matrix_input_buffer #(
  parameter int DATA_WIDTH          = 8,
  parameter int N                   = 4,
  parameter int MAX_MATRIX_LENGTH   = 64,
  parameter int MEMORY_ADDRESS_BITS = 64,
  parameter int COUNTER_BITS        = $clog2(MAX_MATRIX_LENGTH + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           instruction_valid,
  output logic                           instruction_ready,
  input  logic [MEMORY_ADDRESS_BITS-1:0] address_input,
  input  logic [COUNTER_BITS-1:0]        length_input,
  input  logic [COUNTER_BITS-1:0]        repeats_input,
  output logic                           mem_req_valid,
  input  logic                           mem_req_ready,
  output logic [MEMORY_ADDRESS_BITS-1:0] mem_req_address,
  input  logic                           mem_resp_valid,
  input  logic [N*DATA_WIDTH-1:0]        mem_resp_data,
  output logic                           data_valid,
  input  logic                           data_ready,
  output logic [N*DATA_WIDTH-1:0]        data_out,
  output logic                           data_last
);
  localparam int VW = N * DATA_WIDTH;
  localparam int IW = (MAX_MATRIX_LENGTH > 1) ? $clog2(MAX_MATRIX_LENGTH) : 1;
  localparam logic [COUNTER_BITS-1:0]        MAX_LEN = COUNTER_BITS'(MAX_MATRIX_LENGTH);
  localparam logic [COUNTER_BITS-1:0]        ONE     = COUNTER_BITS'(1);
  localparam logic [MEMORY_ADDRESS_BITS-1:0] STRIDE  = MEMORY_ADDRESS_BITS'(N);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;
  state_t state, state_nxt;

  logic [COUNTER_BITS-1:0] len, rep, req_cnt, resp_cnt, idx, pass;
  logic [COUNTER_BITS-1:0] len_clamped, len_m1, rep_m1;
  logic [VW-1:0]           buffer [MAX_MATRIX_LENGTH];

  logic instr_hs, req_hs, resp_take, load_done, data_hs, at_last, final_beat;

  assign len_clamped = (length_input > MAX_LEN) ? MAX_LEN : length_input;
  assign len_m1      = len - ONE;
  assign rep_m1      = rep - ONE;

  assign instruction_ready = (state == IDLE);
  assign mem_req_valid     = (state == LOAD) && (req_cnt < len);
  assign data_valid        = (state == STREAM);
  assign at_last           = (idx == len_m1);
  assign data_last         = data_valid && at_last;
  assign data_out          = data_valid ? buffer[idx[IW-1:0]] : '0;

  assign instr_hs   = instruction_valid && instruction_ready;
  assign req_hs     = mem_req_valid && mem_req_ready;
  // Only beats answering an issued request are taken, so stray beats never shift the fill order.
  assign resp_take  = (state == LOAD) && mem_resp_valid && (resp_cnt < req_cnt);
  assign load_done  = resp_take && (resp_cnt == len_m1);
  assign data_hs    = data_valid && data_ready;
  assign final_beat = data_hs && at_last && (pass == rep_m1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (instr_hs && (length_input != '0) && (repeats_input != '0)) state_nxt = LOAD;
      LOAD:   if (load_done)  state_nxt = STREAM;
      STREAM: if (final_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req_address <= '0;
      len      <= '0;
      rep      <= '0;
      req_cnt  <= '0;
      resp_cnt <= '0;
      idx      <= '0;
      pass     <= '0;
    end else if (instr_hs) begin
      mem_req_address <= address_input;
      len      <= len_clamped;
      rep      <= repeats_input;
      req_cnt  <= '0;
      resp_cnt <= '0;
      idx      <= '0;
      pass     <= '0;
    end else begin
      if (req_hs) begin
        req_cnt         <= req_cnt + ONE;
        mem_req_address <= mem_req_address + STRIDE;
      end
      if (resp_take) resp_cnt <= resp_cnt + ONE;
      if (data_hs) begin
        if (at_last) begin
          idx  <= '0;
          pass <= pass + ONE;
        end else begin
          idx  <= idx + ONE;
        end
      end
    end
  end

  // Storage is deliberately unreset; contents survive across instructions.
  always_ff @(posedge clk) begin
    if (resp_take) buffer[resp_cnt[IW-1:0]] <= mem_resp_data;
  end

endmodule

// File: tb/tb_matrix_input_buffer.sv
// Directed bench for matrix_input_buffer: in-order 1-cycle memory model, stream capture,
// immediate-assertion checks at each step.
module tb_matrix_input_buffer;
  localparam int DW = 8, NV = 4, MAXL = 64, AB = 64, CB = 7;

  logic            clk, reset;
  logic            instruction_valid, instruction_ready;
  logic [AB-1:0]   address_input;
  logic [CB-1:0]   length_input, repeats_input;
  logic            mem_req_valid, mem_req_ready;
  logic [AB-1:0]   mem_req_address;
  logic            mem_resp_valid;
  logic [NV*DW-1:0] mem_resp_data;
  logic            data_valid, data_ready, data_last;
  logic [NV*DW-1:0] data_out;

  logic            resp_v, stale_v, rhs, act;
  logic [31:0]     resp_d;
  logic [AB-1:0]   ra;
  logic [63:0]     req_q[$];
  logic [32:0]     out_q[$];
  int              n_pass, n_total;

  matrix_input_buffer #(.DATA_WIDTH(DW), .N(NV), .MAX_MATRIX_LENGTH(MAXL),
                        .MEMORY_ADDRESS_BITS(AB), .COUNTER_BITS(CB)) dut (
    .clk(clk), .reset(reset),
    .instruction_valid(instruction_valid), .instruction_ready(instruction_ready),
    .address_input(address_input), .length_input(length_input), .repeats_input(repeats_input),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_address(mem_req_address),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .data_valid(data_valid), .data_ready(data_ready), .data_out(data_out), .data_last(data_last)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mk(input logic [63:0] a);
    logic [7:0] b, h;
    b = a[7:0];
    h = a[15:8];
    return {b + 8'd3, b + 8'd2, b + 8'd1, b} ^ {4{h}};
  endfunction

  assign mem_resp_valid = resp_v | stale_v;
  assign mem_resp_data  = stale_v ? 32'hDEADBEEF : resp_d;

  // Memory: answers each accepted request exactly one cycle later, in order.
  initial begin
    resp_v = 0;
    resp_d = '0;
    forever begin
      @(negedge clk);
      rhs = reset && mem_req_valid && mem_req_ready;
      ra  = mem_req_address;
      @(posedge clk);
      #1;
      resp_v = rhs;
      resp_d = rhs ? mk(ra) : '0;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      if (mem_req_valid && mem_req_ready) req_q.push_back(mem_req_address);
      if (data_valid && data_ready) out_q.push_back({data_last, data_out});
      if (mem_req_valid || data_valid) act = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [63:0] a, input int l, input int r);
    instruction_valid = 1;
    address_input = a;
    length_input = CB'(l);
    repeats_input = CB'(r);
    tick();
    instruction_valid = 0;
  endtask

  task automatic wait_idle(input int maxc, input string tag);
    int n = 0;
    @(negedge clk);
    while (!instruction_ready && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(instruction_ready), 64'd1);
  endtask

  task automatic wait_valid(input int maxc, input string tag);
    int n = 0;
    @(negedge clk);
    while (!data_valid && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(data_valid), 64'd1);
  endtask

  function automatic logic [63:0] req_at(input int i);
    return (i < req_q.size()) ? req_q[i] : '1;
  endfunction

  function automatic logic [32:0] out_at(input int i);
    return (i < out_q.size()) ? out_q[i] : '1;
  endfunction

  task automatic clear_logs();
    req_q.delete();
    out_q.delete();
    act = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] s;
    int errs;
    logic [63:0] base, a;
    n_pass = 0; n_total = 0;
    reset = 0; instruction_valid = 0; address_input = '0;
    length_input = '0; repeats_input = '0;
    mem_req_ready = 1; data_ready = 1; stale_v = 0; act = 0;

    // Reset state
    #3;
    chk("rst_instr_ready", 64'(instruction_ready), 64'd1);
    chk("rst_req_valid",   64'(mem_req_valid), 64'd0);
    chk("rst_data_valid",  64'(data_valid), 64'd0);
    chk("rst_data_last",   64'(data_last), 64'd0);
    chk("rst_req_addr",    mem_req_address, 64'd0);
    chk("rst_data_out",    64'(data_out), 64'd0);
    tick(); tick();
    reset = 1;
    tick();

    // Basic: base 0x100, L=2, R=1
    clear_logs();
    issue(64'h100, 2, 1);
    @(negedge clk);
    chk("basic_first_req_valid", 64'(mem_req_valid), 64'd1);
    chk("basic_first_req_addr", mem_req_address, 64'h100);
    wait_idle(50, "basic_done");
    chk("basic_nreq", 64'(req_q.size()), 64'd2);
    chk("basic_req1", req_at(1), 64'h104);
    chk("basic_nout", 64'(out_q.size()), 64'd2);
    chk("basic_v0", 64'(out_at(0)), {31'd0, 33'h0_0203_0001});
    chk("basic_v1", 64'(out_at(1)), {31'd0, 33'h1_0607_0405});
    tick();

    // Repeats with toggling data_ready: L=3, R=2
    clear_logs();
    data_ready = 0;
    issue(64'h200, 3, 2);
    wait_valid(50, "rep_stream_start");
    for (int k = 0; k < 6; k++) begin
      chk("rep_valid", 64'(data_valid), 64'd1);
      chk("rep_data", 64'(data_out), 64'(mk(64'h200 + 64'(4 * (k % 3)))));
      chk("rep_last", 64'(data_last), 64'((k % 3) == 2));
      s = {data_last, data_out};
      tick();
      data_ready = 1;
      @(negedge clk);
      chk("rep_stable", 64'({data_last, data_out}), 64'(s));
      tick();
      data_ready = 0;
      @(negedge clk);
    end
    chk("rep_end_valid", 64'(data_valid), 64'd0);
    chk("rep_end_ready", 64'(instruction_ready), 64'd1);
    chk("rep_nout", 64'(out_q.size()), 64'd6);
    tick();
    data_ready = 1;

    // Degenerate instructions
    clear_logs();
    issue(64'h300, 0, 5);
    @(negedge clk);
    chk("degen_l0_ready", 64'(instruction_ready), 64'd1);
    tick();
    issue(64'h300, 4, 0);
    @(negedge clk);
    chk("degen_r0_ready", 64'(instruction_ready), 64'd1);
    repeat (4) tick();
    chk("degen_no_activity", 64'(act), 64'd0);

    // Clamp and wrap: L=MAX+10, R=2, base 2^64-4
    clear_logs();
    base = 64'hFFFF_FFFF_FFFF_FFFC;
    issue(base, MAXL + 10, 2);
    wait_idle(1000, "clamp_done");
    chk("clamp_nreq", 64'(req_q.size()), 64'(MAXL));
    chk("clamp_req0", req_at(0), base);
    chk("clamp_req1_wrap", req_at(1), 64'd0);
    chk("clamp_req_last", req_at(MAXL - 1), 64'hF8);
    chk("clamp_nout", 64'(out_q.size()), 64'(2 * MAXL));
    chk("clamp_out1", 64'(out_at(1)), {31'd0, 33'h0_0302_0100});
    errs = 0;
    for (int i = 0; i < 2 * MAXL; i++) begin
      a = base + 64'(4 * (i % MAXL));
      if (out_at(i) !== {((i % MAXL) == MAXL - 1), mk(a)}) errs++;
    end
    chk("clamp_all_outputs", 64'(errs), 64'd0);
    tick();

    // Memory backpressure: 5-cycle stall after the first request
    clear_logs();
    issue(64'h300, 4, 1);
    @(negedge clk);
    chk("bp_req0_addr", mem_req_address, 64'h300);
    tick();
    mem_req_ready = 0;
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!mem_req_valid || mem_req_address !== 64'h304) errs++;
      tick();
    end
    chk("bp_stall_hold", 64'(errs), 64'd0);
    mem_req_ready = 1;
    wait_idle(100, "bp_done");
    chk("bp_nreq", 64'(req_q.size()), 64'd4);
    chk("bp_req3", req_at(3), 64'h30C);
    chk("bp_nout", 64'(out_q.size()), 64'd4);
    errs = 0;
    for (int i = 0; i < 4; i++)
      if (out_at(i) !== {(i == 3), mk(64'h300 + 64'(4 * i))}) errs++;
    chk("bp_order", 64'(errs), 64'd0);
    tick();

    // Reset mid-STREAM, then stale beats, then a fresh L=1, R=1
    clear_logs();
    issue(64'h400, 4, 2);
    wait_valid(50, "mid_stream_start");
    repeat (3) tick();
    chk("mid_handshakes", 64'(out_q.size()), 64'd3);
    reset = 0;
    #1;
    chk("mid_rst_instr_ready", 64'(instruction_ready), 64'd1);
    chk("mid_rst_data_valid",  64'(data_valid), 64'd0);
    chk("mid_rst_data_last",   64'(data_last), 64'd0);
    chk("mid_rst_data_out",    64'(data_out), 64'd0);
    chk("mid_rst_req_valid",   64'(mem_req_valid), 64'd0);
    chk("mid_rst_req_addr",    mem_req_address, 64'd0);
    tick();
    reset = 1;
    stale_v = 1;
    tick(); tick();
    stale_v = 0;
    @(negedge clk);
    chk("post_rst_idle", 64'(instruction_ready), 64'd1);
    tick();
    clear_logs();
    issue(64'h500, 1, 1);
    wait_idle(50, "post_rst_done");
    chk("post_rst_nout", 64'(out_q.size()), 64'd1);
    chk("post_rst_v0", 64'(out_at(0)), {31'd0, 1'b1, mk(64'h500)});
    chk("post_rst_nreq", 64'(req_q.size()), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
